// File: rtl/jump_pkg.sv
// Shared types and widths for the jump game-flow blocks.
package jump_pkg;
    localparam int SCORE_W = 16;
    localparam int X_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        CHARGE,
        FLY,
        JUDGE,
        RELOAD,
        OVER
    } state_t;
endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button, with one-cycle rise/fall pulses
// taken from the synchronized level.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [2:0] sync_pipe;

    always_ff @(posedge clk) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[1:0], i_btn};
    end

    assign o_level = sync_pipe[1];
    assign o_rise  = sync_pipe[1] & ~sync_pipe[2];
    assign o_fall  = ~sync_pipe[1] & sync_pipe[2];
endmodule

// File: rtl/jump_judge.sv
// Game-flow controller: charge on button hold, animate the flight, judge the landing,
// drive reload handshake and keep the score. Optional JUMP_PERFECT_BONUS_EN adds o_perfect.
module jump_judge
    import jump_pkg::*;
#(
    parameter int X_W          = X_W_DEF,
    parameter int PLAYER_X0    = 100,
    parameter int CHARGE_DIV   = 2500,
    parameter int CHARGE_MAX   = 400,
    parameter int FLY_DIV      = 1000,
    parameter int JUMP_STEP    = 4,
    parameter int BLOCK_HALF_W = 20
) (
    input  logic               clk_machine,
    input  logic               rst_machine,
    input  logic               i_btn,
    input  logic [X_W-1:0]     i_x_block1,
    input  logic [X_W-1:0]     i_x_block2,
    input  logic               i_en_block2,
    input  logic               i_reload_done,
    output logic               o_reload,
    output logic [X_W-1:0]     o_x_player,
    output logic [X_W-1:0]     o_charge,
    output logic [SCORE_W-1:0] o_score,
`ifdef JUMP_PERFECT_BONUS_EN
    output logic               o_perfect,
`endif
    output logic               o_game_over
);
    localparam logic [31:0]    CDIV_M1 = 32'(CHARGE_DIV - 1);
    localparam logic [31:0]    FDIV_M1 = 32'(FLY_DIV - 1);
    localparam logic [X_W-1:0] X0      = X_W'(PLAYER_X0);
    localparam logic [X_W-1:0] CMAX    = X_W'(CHARGE_MAX);
    localparam logic [X_W-1:0] HALF_W  = X_W'(BLOCK_HALF_W);
    localparam logic [X_W-1:0] PERF_W  = X_W'(BLOCK_HALF_W / 4);

    state_t               state, state_nxt;
    logic [X_W-1:0]       x_q, x_nxt, charge_q, charge_nxt, target_q, target_nxt;
    logic [SCORE_W-1:0]   score_q, score_nxt;
    logic [31:0]          presc_q, presc_nxt;
    logic                 btn_rise, btn_fall, btn_lvl_unused, unused_x1;
    logic [X_W:0]         tgt_sum, step_sum;
    logic [X_W-1:0]       diff;
    logic [SCORE_W:0]     score_sum;
    logic                 hit, perfect_hit;

    // Block 1 position is informational only; landing is judged against block 2.
    assign unused_x1 = ^i_x_block1;

    btn_sync_edge u_btn (
        .clk     (clk_machine),
        .rst     (rst_machine),
        .i_btn   (i_btn),
        .o_level (btn_lvl_unused),
        .o_rise  (btn_rise),
        .o_fall  (btn_fall)
    );

    assign tgt_sum     = {1'b0, x_q} + {1'b0, charge_q};
    assign step_sum    = {1'b0, x_q} + (X_W + 1)'(JUMP_STEP);
    assign diff        = (target_q >= i_x_block2) ? target_q - i_x_block2 : i_x_block2 - target_q;
    assign hit         = i_en_block2 && (diff <= HALF_W);
`ifdef JUMP_PERFECT_BONUS_EN
    assign perfect_hit = hit && (diff <= PERF_W);
`else
    assign perfect_hit = 1'b0;
`endif
    assign score_sum   = {1'b0, score_q} + (perfect_hit ? (SCORE_W + 1)'(2) : (SCORE_W + 1)'(1));

    always_comb begin
        state_nxt  = state;
        x_nxt      = x_q;
        charge_nxt = charge_q;
        target_nxt = target_q;
        score_nxt  = score_q;
        presc_nxt  = presc_q + 32'd1;
        case (state)
            IDLE: if (btn_rise) begin
                state_nxt  = CHARGE;
                charge_nxt = '0;
            end
            CHARGE: begin
                if (btn_fall) begin
                    target_nxt = tgt_sum[X_W] ? '1 : tgt_sum[X_W-1:0];
                    state_nxt  = FLY;
                end else if (presc_q == CDIV_M1) begin
                    presc_nxt = '0;
                    if (charge_q < CMAX) charge_nxt = charge_q + X_W'(1);
                end
            end
            FLY: begin
                if (x_q == target_q) begin
                    state_nxt = JUDGE;
                end else if (presc_q == FDIV_M1) begin
                    presc_nxt = '0;
                    x_nxt     = (step_sum >= {1'b0, target_q}) ? target_q : step_sum[X_W-1:0];
                end
            end
            JUDGE: begin
                if (hit) begin
                    score_nxt = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    state_nxt = RELOAD;
                end else begin
                    state_nxt = OVER;
                end
            end
            RELOAD: if (i_reload_done) begin
                x_nxt      = X0;
                charge_nxt = '0;
                state_nxt  = IDLE;
            end
            OVER: if (btn_rise) begin
                score_nxt  = '0;
                x_nxt      = X0;
                charge_nxt = '0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) presc_nxt = '0;
    end

    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            state    <= IDLE;
            x_q      <= X0;
            charge_q <= '0;
            target_q <= X0;
            score_q  <= '0;
            presc_q  <= '0;
        end else begin
            state    <= state_nxt;
            x_q      <= x_nxt;
            charge_q <= charge_nxt;
            target_q <= target_nxt;
            score_q  <= score_nxt;
            presc_q  <= presc_nxt;
        end
    end

    assign o_reload    = (state == RELOAD);
    assign o_game_over = (state == OVER);
    assign o_x_player  = x_q;
    assign o_charge    = charge_q;
    assign o_score     = score_q;
`ifdef JUMP_PERFECT_BONUS_EN
    assign o_perfect   = (state == JUDGE) && perfect_hit;
`endif
endmodule

// File: tb/tb_jump_judge.sv
// Scoreboard bench for jump_judge: judge outcomes are queued at stimulus time and
// checked by a monitor when o_reload or o_game_over rises.
module tb_jump_judge;
    localparam int X_W = 32;
`ifdef JUMP_PERFECT_BONUS_EN
    localparam int PB = 2;
`else
    localparam int PB = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn = 1'b0;
    logic [X_W-1:0] x_block1 = 32'd100;
    logic [X_W-1:0] x_block2 = 32'd160;
    logic          en_block2 = 1'b1;
    logic          reload_done = 1'b0;
    logic          o_reload, o_game_over;
    logic [X_W-1:0] o_x_player, o_charge;
    logic [15:0]   o_score;
`ifdef JUMP_PERFECT_BONUS_EN
    logic          o_perfect;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        bit          is_over;
        logic [15:0] score;
        bit          perf;
    } exp_t;
    exp_t exp_q[$];

    jump_judge #(
        .X_W(X_W), .PLAYER_X0(100), .CHARGE_DIV(2), .CHARGE_MAX(400),
        .FLY_DIV(1), .JUMP_STEP(4), .BLOCK_HALF_W(20)
    ) dut (
        .clk_machine   (clk),
        .rst_machine   (rst),
        .i_btn         (btn),
        .i_x_block1    (x_block1),
        .i_x_block2    (x_block2),
        .i_en_block2   (en_block2),
        .i_reload_done (reload_done),
        .o_reload      (o_reload),
        .o_x_player    (o_x_player),
        .o_charge      (o_charge),
        .o_score       (o_score),
`ifdef JUMP_PERFECT_BONUS_EN
        .o_perfect     (o_perfect),
`endif
        .o_game_over   (o_game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Monitor: pops one expected outcome per judge result presented by the DUT.
    logic prev_reload = 1'b0, prev_over = 1'b0;
    int   perf_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if ((o_reload && !prev_reload) || (o_game_over && !prev_over)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_outcome", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("outcome_is_over", 32'(o_game_over), 32'(e.is_over));
                check("outcome_score", 32'(o_score), 32'(e.score));
`ifdef JUMP_PERFECT_BONUS_EN
                check("perfect_pulses", 32'(perf_cnt), e.perf ? 32'd1 : 32'd0);
`endif
            end
            perf_cnt = 0;
        end
`ifdef JUMP_PERFECT_BONUS_EN
        if (o_perfect) perf_cnt++;
`endif
        prev_reload = o_reload;
        prev_over   = o_game_over;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Button sampled high on n consecutive edges; CHARGE lasts n-1 non-fall cycles.
    task automatic press(input int n);
        @(negedge clk) btn = 1'b1;
        cycles(n);
        btn = 1'b0;
    endtask

    task automatic wait_out(input string nm, input bit over);
        int n = 0;
        while (!(over ? o_game_over : o_reload) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(over ? o_game_over : o_reload), 32'd1);
    endtask

    task automatic pulse_done();
        @(negedge clk) reload_done = 1'b1;
        @(negedge clk) reload_done = 1'b0;
    endtask

    task automatic push(input bit over, input int score, input bit perf);
        exp_t e;
        e.is_over = over;
        e.score   = 16'(score);
        e.perf    = perf;
        exp_q.push_back(e);
    endtask

    initial begin
        // 1: reset state and quiet IDLE
        cycles(3);
        check("rst_reload", 32'(o_reload), 32'd0);
        check("rst_x", o_x_player, 32'd100);
        check("rst_charge", o_charge, 32'd0);
        check("rst_score", 32'(o_score), 32'd0);
        check("rst_over", 32'(o_game_over), 32'd0);
        rst = 1'b0;
        cycles(10);
        check("idle_reload", 32'(o_reload), 32'd0);
        check("idle_charge", o_charge, 32'd0);

        // 2: charge 60 -> target 160 -> exact hit
        push(1'b0, PB, 1'b1);
        press(121);
        wait_out("hit_reload", 1'b0);
        check("hit_charge", o_charge, 32'd60);
        check("hit_x_landed", o_x_player, 32'd160);
        press(3);
        cycles(10);
        check("reload_ignores_btn", 32'(o_reload), 32'd1);
        check("reload_charge_kept", o_charge, 32'd60);
        pulse_done();
        check("after_reload_x", o_x_player, 32'd100);
        check("after_reload_charge", o_charge, 32'd0);
        check("after_reload_flag", 32'(o_reload), 32'd0);
        pulse_done();
        cycles(3);
        check("idle_done_reload", 32'(o_reload), 32'd0);
        check("idle_done_x", o_x_player, 32'd100);
        check("idle_done_score", 32'(o_score), 32'(PB));

        // 3: charge 30 -> target 130 -> miss, then restart
        push(1'b1, PB, 1'b0);
        press(61);
        wait_out("miss_over", 1'b1);
        check("miss_x", o_x_player, 32'd130);
        press(5);
        cycles(30);
        check("restart_over", 32'(o_game_over), 32'd0);
        check("restart_score", 32'(o_score), 32'd0);
        check("restart_charge", o_charge, 32'd0);
        check("restart_x", o_x_player, 32'd100);

        // 6: near-perfect (diff 2) and plain hit (diff 10)
        push(1'b0, PB, 1'b1);
        press(125);
        wait_out("t162_reload", 1'b0);
        pulse_done();
        push(1'b0, PB + 1, 1'b0);
        press(141);
        wait_out("t170_reload", 1'b0);
        pulse_done();

        // 5: score saturation
        @(negedge clk);
        force dut.score_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.score_q;
        @(negedge clk);
        check("sat_preload", 32'(o_score), 32'hFFFF);
        push(1'b0, 16'hFFFF, 1'b1);
        press(121);
        wait_out("sat_reload", 1'b0);
        pulse_done();

        // 4: charge saturates at 400, reset mid-flight
        @(negedge clk) btn = 1'b1;
        cycles(950);
        check("charge_sat", o_charge, 32'd400);
        btn = 1'b0;
        cycles(10);
        check("mid_fly_x", o_x_player, 32'd128);
        rst = 1'b1;
        @(negedge clk);
        check("fly_rst_x", o_x_player, 32'd100);
        check("fly_rst_charge", o_charge, 32'd0);
        check("fly_rst_score", 32'(o_score), 32'd0);
        rst = 1'b0;
        cycles(5);

        // reset abandons a reload in flight
        push(1'b0, PB, 1'b1);
        press(121);
        wait_out("rst_reload_pre", 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("reload_rst_flag", 32'(o_reload), 32'd0);
        check("reload_rst_score", 32'(o_score), 32'd0);
        rst = 1'b0;
        cycles(5);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
